// File: rtl/bird_physics_if.sv
// Player-sprite physics bus: per-frame controls into the physics engine and
// sprite position/game-state back out to the death detector and renderer.
interface bird_physics_if;
    logic        frame_tick;
    logic        start;
    logic        flap_btn;
    logic        is_dead;
    logic [8:0]  height;
    logic [5:0]  velocity;
    logic        in_game;
    logic        game_over;
    logic [15:0] frames_alive;

    modport master (
        output frame_tick, start, flap_btn, is_dead,
        input  height, velocity, in_game, game_over, frames_alive
    );

    modport slave (
        input  frame_tick, start, flap_btn, is_dead,
        output height, velocity, in_game, game_over, frames_alive
    );
endinterface

// File: rtl/bird_physics.sv
// Per-frame vertical motion engine for the player sprite: integrates gravity and
// flap impulses into the sprite height and owns the IDLE/PLAY/OVER game state.
module bird_physics #(
    parameter int unsigned START_Y      = 240,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned FLAP_IMPULSE = 8,
    parameter int unsigned MAX_FALL     = 10,
    parameter int unsigned Y_FLOOR      = 470
) (
    input  logic          clk,
    input  logic          reset,
    bird_physics_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_OVER} state_t;

    localparam logic [8:0]         START_H  = 9'(START_Y);
    localparam logic signed [6:0]  GRAV_S   = 7'(GRAVITY);
    localparam logic signed [6:0]  FLAP_S   = 7'(FLAP_IMPULSE);
    localparam logic signed [6:0]  MAXF_S   = 7'(MAX_FALL);
    localparam logic signed [10:0] FLOOR_S  = 11'(Y_FLOOR);

    state_t      state_q, state_d;
    logic [8:0]  height_q, height_d;
    logic [5:0]  velocity_q, velocity_d;
    logic [15:0] frames_alive_q, frames_alive_d;
    logic        in_game_q, in_game_d;
    logic        game_over_q, game_over_d;
    logic        flap_pending_q, flap_pending_d;
    logic        flap_prev_q, flap_prev_d;

    logic               flap_rise;
    logic               flap;
    logic signed [6:0]  vel_ext;
    logic signed [6:0]  vel_grav;
    logic signed [6:0]  vel_n;
    logic signed [10:0] h_sum;
    logic [8:0]         h_n;

    // Velocity/height integration is computed every cycle and only committed on a tick
    always_comb begin
        flap_rise = bus.flap_btn & ~flap_prev_q;
        flap      = flap_rise | flap_pending_q;
        vel_ext   = {velocity_q[5], velocity_q};
        vel_grav  = vel_ext + GRAV_S;
        if (flap) begin
            vel_n = -FLAP_S;
        end else if (vel_grav > MAXF_S) begin
            vel_n = MAXF_S;
        end else begin
            vel_n = vel_grav;
        end
        h_sum = $signed({2'b00, height_q}) + {{4{vel_n[6]}}, vel_n};
        if (h_sum < 11'sd0) begin
            h_n = 9'd0;
        end else if (h_sum > FLOOR_S) begin
            h_n = FLOOR_S[8:0];
        end else begin
            h_n = h_sum[8:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        height_d       = height_q;
        velocity_d     = velocity_q;
        frames_alive_d = frames_alive_q;
        flap_pending_d = flap_pending_q;
        flap_prev_d    = bus.flap_btn;

        case (state_q)
            ST_IDLE: begin
                height_d       = START_H;
                velocity_d     = 6'd0;
                frames_alive_d = 16'd0;
                if (bus.start) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.frame_tick) begin
                    height_d       = h_n;
                    velocity_d     = vel_n[5:0];
                    flap_pending_d = 1'b0;
                    if (frames_alive_q != 16'hFFFF) begin
                        frames_alive_d = frames_alive_q + 16'd1;
                    end
                end else begin
                    flap_pending_d = flap_pending_q | flap_rise;
                end
                if (bus.is_dead) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                // Reload on the way out so IDLE never shows the frozen OVER values
                if (bus.start) begin
                    state_d        = ST_IDLE;
                    height_d       = START_H;
                    velocity_d     = 6'd0;
                    frames_alive_d = 16'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_PLAY) begin
            flap_pending_d = 1'b0;
        end
        in_game_d   = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            height_q       <= START_H;
            velocity_q     <= 6'd0;
            frames_alive_q <= 16'd0;
            in_game_q      <= 1'b0;
            game_over_q    <= 1'b0;
            flap_pending_q <= 1'b0;
            flap_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            height_q       <= height_d;
            velocity_q     <= velocity_d;
            frames_alive_q <= frames_alive_d;
            in_game_q      <= in_game_d;
            game_over_q    <= game_over_d;
            flap_pending_q <= flap_pending_d;
            flap_prev_q    <= flap_prev_d;
        end
    end

    assign bus.height       = height_q;
    assign bus.velocity     = velocity_q;
    assign bus.in_game      = in_game_q;
    assign bus.game_over    = game_over_q;
    assign bus.frames_alive = frames_alive_q;
endmodule

// File: tb/tb_bird_physics.sv
// Directed scoreboard bench for bird_physics: stimulus queues hand-computed
// expectations tagged with a cycle; a negedge monitor pops and compares them.
module tb_bird_physics;
    logic clk;
    logic reset;
    bird_physics_if bus ();

    bird_physics dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          stamp;
        logic [8:0]  h;
        logic [5:0]  v;
        logic        ig;
        logic        go;
        logic [15:0] fa;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due on this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.stamp != cyc || bus.height !== e.h || bus.velocity !== e.v ||
                bus.in_game !== e.ig || bus.game_over !== e.go || bus.frames_alive !== e.fa) begin
                errors++;
                $display("FAIL %s @%0d: got h=%0d v=%0d ig=%b go=%b fa=%h, want h=%0d v=%0d ig=%b go=%b fa=%h (due %0d)",
                         e.name, cyc, bus.height, $signed(bus.velocity), bus.in_game, bus.game_over,
                         bus.frames_alive, e.h, $signed(e.v), e.ig, e.go, e.fa, e.stamp);
            end else begin
                $display("ok   %s @%0d: h=%0d v=%0d ig=%b go=%b fa=%h", e.name, cyc, bus.height,
                         $signed(bus.velocity), bus.in_game, bus.game_over, bus.frames_alive);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit ft, input bit st, input bit fl, input bit dead);
        bus.frame_tick = ft;
        bus.start      = st;
        bus.flap_btn   = fl;
        bus.is_dead    = dead;
        step();
    endtask

    task automatic expect_out(input string name, input int h, input int v, input bit ig,
                              input bit go, input int fa);
        exp_t e;
        e.name  = name;
        e.stamp = cyc;
        e.h     = 9'(h);
        e.v     = 6'(v);
        e.ig    = ig;
        e.go    = go;
        e.fa    = 16'(fa);
        sb.push_back(e);
    endtask

    // Free-fall from rest at 240: velocity then height after each tick
    int fall_v [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10, 10, 10};
    int fall_h [15] = '{241, 243, 246, 250, 255, 261, 268, 276, 285, 295, 305, 315, 325, 335, 345};

    initial begin
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.flap_btn   = 1'b0;
        bus.is_dead    = 1'b0;
        reset          = 1'b0;
        step();
        step();
        expect_out("reset", 240, 0, 0, 0, 0);
        reset = 1'b1;

        apply(0, 0, 0, 1);
        expect_out("idle_ignores_dead", 240, 0, 0, 0, 0);
        apply(1, 1, 0, 0);
        expect_out("start_play", 240, 0, 1, 0, 0);

        for (int i = 0; i < 15; i++) begin
            apply(1, 0, 0, 0);
            expect_out($sformatf("fall_%0d", i + 1), fall_h[i], fall_v[i], 1, 0, i + 1);
        end
        apply(0, 1, 0, 0);
        expect_out("start_ignored_play", 345, 10, 1, 0, 15);
        apply(0, 0, 0, 0);
        expect_out("no_tick_hold", 345, 10, 1, 0, 15);

        reset = 1'b0;
        apply(1, 0, 1, 0);
        expect_out("reset_mid_play", 240, 0, 0, 0, 0);
        reset = 1'b1;
        apply(0, 1, 0, 0);
        expect_out("restart_play", 240, 0, 1, 0, 0);

        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 0);
        end
        expect_out("fall_to_v5", 255, 5, 1, 0, 5);
        apply(1, 0, 1, 0);
        expect_out("flap_with_tick", 247, -8, 1, 0, 6);
        apply(0, 0, 0, 0);
        apply(0, 0, 1, 0);
        apply(0, 0, 0, 0);
        apply(0, 0, 1, 0);
        expect_out("pending_no_move", 247, -8, 1, 0, 6);
        apply(1, 0, 0, 0);
        expect_out("two_rises_one_flap", 239, -8, 1, 0, 7);
        apply(1, 0, 0, 0);
        expect_out("after_flap_grav", 232, -7, 1, 0, 8);
        apply(1, 0, 0, 0);
        expect_out("grav_again", 226, -6, 1, 0, 9);

        for (int k = 1; k <= 29; k++) begin
            apply(0, 0, 0, 0);
            apply(1, 0, 1, 0);
            if (k == 28) expect_out("climb_h2", 2, -8, 1, 0, 37);
        end
        expect_out("ceiling_clamp", 0, -8, 1, 0, 38);

        apply(0, 0, 0, 0);
        apply(1, 0, 1, 1);
        expect_out("dead_to_over", 0, -8, 0, 1, 39);
        apply(0, 0, 0, 0);
        apply(1, 0, 1, 0);
        apply(1, 0, 0, 1);
        expect_out("over_frozen", 0, -8, 0, 1, 39);
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 0);
        expect_out("over_to_idle", 240, 0, 0, 0, 0);
        apply(0, 1, 0, 0);
        expect_out("idle_to_play", 240, 0, 1, 0, 0);

        for (int i = 0; i < 27; i++) begin
            apply(1, 0, 0, 0);
        end
        expect_out("near_floor", 465, 10, 1, 0, 27);
        apply(1, 0, 0, 0);
        expect_out("floor_clamp", 470, 10, 1, 0, 28);
        apply(1, 0, 0, 0);
        expect_out("floor_hold", 470, 10, 1, 0, 29);

        for (int i = 0; i < 65535 - 29 - 1; i++) begin
            apply(1, 0, 0, 0);
        end
        expect_out("fa_fffe", 470, 10, 1, 0, 16'hFFFE);
        apply(1, 0, 0, 0);
        expect_out("fa_ffff", 470, 10, 1, 0, 16'hFFFF);
        apply(1, 0, 0, 0);
        expect_out("fa_saturate", 470, 10, 1, 0, 16'hFFFF);
        apply(0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            step();
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations still queued, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
